bulls_cows_game_ctrl: RTL

BULLS_COWS_GAME_CTRL -- requirements
Module: bulls_cows_game_ctrl

---
 rtl/bulls_cows_game_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/bulls_cows_game_ctrl.sv
// Two-digit Bulls & Cows game controller.
// A legal value has two distinct BCD digits. Each accepted guess is scored
// against the stored secret one cycle later, as one-hot bull/cow counts.
module bulls_cows_game_ctrl #(
  parameter int MAX_TRIES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_secret,
  input  logic [7:0] secret_in,
  input  logic       guess_valid,
  input  logic [7:0] guess_in,
  output logic [2:0] bulls,
  output logic [2:0] cows,
  output logic       result_valid,
  output logic       err,
  output logic [3:0] attempts,
  output logic       ready,
  output logic       win,
  output logic       lose
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_EVAL  = 3'd2;
  localparam logic [2:0] S_WIN   = 3'd3;
  localparam logic [2:0] S_LOSE  = 3'd4;

  localparam logic [3:0] MAX_ATT = 4'(MAX_TRIES);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [7:0] secret;
  logic [7:0] guess;
  logic [1:0] bull_n;
  logic [1:0] cow_n;
  logic       secret_ok;
  logic       guess_take;

  function automatic logic is_legal(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v[7:4] != v[3:0]);
  endfunction

  function automatic logic [1:0] match_cnt(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic [2:0] to_onehot(input logic [1:0] n);
    case (n)
      2'd2:    return 3'b100;
      2'd1:    return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  // A legal secret overrides everything; a guess arriving alongside any
  // set_secret strobe is dropped, so only a lone guess in ARMED is considered.
  always_comb begin
    secret_ok  = set_secret && is_legal(secret_in);
    guess_take = (state == S_ARMED) && guess_valid && !set_secret;
    bull_n     = match_cnt(guess[7:4] == secret[7:4], guess[3:0] == secret[3:0]);
    cow_n      = match_cnt(guess[7:4] == secret[3:0], guess[3:0] == secret[7:4]);
  end

  // Next-state selection for the game FSM.
  always_comb begin
    state_nxt = state;
    if (secret_ok) begin
      state_nxt = S_ARMED;
    end else begin
      case (state)
        S_ARMED: if (guess_take && is_legal(guess_in)) state_nxt = S_EVAL;
        S_EVAL: begin
          if (bull_n == 2'd2)          state_nxt = S_WIN;
          else if (attempts == MAX_ATT) state_nxt = S_LOSE;
          else                          state_nxt = S_ARMED;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // State, stored operands and all registered outputs.
  // Status levels are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      secret       <= 8'h00;
      guess        <= 8'h00;
      attempts     <= 4'd0;
      bulls        <= 3'b001;
      cows         <= 3'b001;
      result_valid <= 1'b0;
      err          <= 1'b0;
      ready        <= 1'b0;
      win          <= 1'b0;
      lose         <= 1'b0;
    end else begin
      state        <= state_nxt;
      ready        <= (state_nxt == S_ARMED);
      win          <= (state_nxt == S_WIN);
      lose         <= (state_nxt == S_LOSE);
      result_valid <= 1'b0;
      err          <= set_secret && !secret_ok;
      if (secret_ok) begin
        secret   <= secret_in;
        attempts <= 4'd0;
        bulls    <= 3'b001;
        cows     <= 3'b001;
      end else begin
        if (guess_take) begin
          if (is_legal(guess_in)) begin
            guess <= guess_in;
            if (attempts < MAX_ATT) attempts <= attempts + 4'd1;
          end else begin
            err <= 1'b1;
          end
        end
        if (state == S_EVAL) begin
          bulls        <= to_onehot(bull_n);
          cows         <= to_onehot(cow_n);
          result_valid <= 1'b1;
        end
      end
    end
  end

endmodule
